mxv_result_tx: RTL and testbench
================================

# mxv_result_tx

Result-frame transmitter for the MxV accelerator: the outbound counterpart of the byte-receive/data-feeder path. When the MxV control FSM enters its transmit phase it pulses `START`. The block snapshots the result vector and serializes it as a framed byte stream to the UART transmitter, one byte per `TX_START`/`TX_DONE` handshake. When the frame is complete it returns `DONE`, which drives the FSM's transmission-done input.

## Interface
- `MAX_N`, 8: maximum result entries (matches 8 matrix RAM rows)
- `RES_W`, 16: width of one result entry; always sent as 2 bytes, MSB first
- `HEADER`, 8'hFE: first byte of every frame
- `TRAILER`, 8'hEF: last byte of every frame
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `START`  in  1  one-cycle request to send a frame; honoured only in IDLE
- `VEC_N`  in  4  number of valid results; sampled with `START`
- `RES_DATA`  in  MAX_N*RES_W  results; entry i at bits [RES_W*i+RES_W-1 : RES_W*i]; sampled with `START`
- `TX_DONE`  in  1  UART transmitter pulse: current byte fully shifted out
- `TX_START`  out  1  one-cycle pulse: load `TX_DATA` into the UART
- `TX_DATA`  out  8  byte to transmit; stable from the `TX_START` cycle until the next `TX_START`
- `BUSY`  out  1  high from the cycle after `START` is accepted until `DONE`
- `DONE`  out  1  one-cycle pulse after the trailer's `TX_DONE`

## Operation
- Frame order: `HEADER`, `LEN`, then for i=0..LEN-1 the entry's high byte followed by its low byte, then `CHK`, then `TRAILER`. Total length is 2*LEN+4 bytes.
- `LEN` is `VEC_N` clamped to `MAX_N`. `VEC_N`=0 gives `LEN`=0, a 4-byte frame. `VEC_N`>8 gives `LEN`=8, and the length byte reads 0x08.
- `CHK` is the XOR of `LEN` and every data byte. `HEADER` and `TRAILER` are excluded.
- On accept, `RES_DATA` and `LEN` are copied into shadow registers. Later input changes do not affect the frame in flight.
- A byte index counts 0..2*LEN+3. A byte mux over the shadow selects the current byte. The checksum accumulates as each data byte is issued.
- FSM states:
  - IDLE: on `START`, capture inputs, index=0, go to SEND.
  - SEND: `TX_START`=1, `TX_DATA`=byte[index], go to WAIT.
  - WAIT: on `TX_DONE`, go to FIN if index==2*LEN+3; otherwise index+1 and go to SEND.
  - FIN: `DONE`=1, go to IDLE.
- `START` in any state other than IDLE is ignored and is not queued.
- `TX_DONE` outside WAIT is ignored. This includes a `TX_DONE` coinciding with the SEND cycle.
- Reset values: state IDLE; `TX_START`, `TX_DATA`, `BUSY`, `DONE`, index, checksum and shadows all 0.
- Reset asserted mid-frame clears everything at once. No `DONE` is produced and the remaining bytes are dropped.

## Timing
- All outputs are registered.
- `START` sampled at edge k: `BUSY` and `TX_START` are high in cycle k+1, and `TX_DATA`=`HEADER` from cycle k+1.
- `TX_DONE` sampled in WAIT at edge m, not the last byte: the next `TX_START` is high in cycle m+1 with the new `TX_DATA`.
- Minimum byte period is 2 cycles (SEND plus one WAIT cycle).
- `TX_DONE` for the trailer at edge m: `DONE` is high in cycle m+1 and `BUSY` is low from cycle m+2.
- A new `START` is accepted at the earliest at edge m+2.
- `TX_START` is never high on two consecutive cycles. `TX_START` and `DONE` are never high together.

## Test plan
- Single result: `VEC_N`=1, entry0=0x1234. Required bytes FE 01 12 34 27 EF, then one `DONE` pulse; `TX_START` count is 6.
- Empty vector: `VEC_N`=0. Required bytes FE 00 00 EF and `DONE`; `RES_DATA` contents have no effect.
- Full vector and clamp: `VEC_N`=9, entries i=0..7 = 0x0101*(i+1). Length byte 08, data 01 01 02 02 .. 08 08, `CHK`=0x08, trailer EF; 20 bytes total.
- Handshake latency: UART model returns `TX_DONE` 10 cycles after each `TX_START`. Check `TX_START` one cycle after `START` and one cycle after each `TX_DONE`. Check `TX_DATA` stable between pulses and `DONE` one cycle after the final `TX_DONE`.
- Robustness:
  - Extra `START` pulses during the frame are ignored.
  - A spurious `TX_DONE` while in IDLE and on a SEND cycle does not advance the index.
  - Changing `RES_DATA` mid-frame does not alter the bytes sent.
- Reset mid-frame: drive `rst` low after the 3rd `TX_DONE`. All outputs read 0 immediately and no `DONE` pulse appears. A following `START` sends a complete, correct frame starting at FE.

Source files
------------

// File: rtl/mxv_result_tx.sv
// mxv_result_tx: snapshots the MxV result vector on START and serializes it
// as HEADER, LEN, {hi,lo} per entry, CHK, TRAILER over a TX_START/TX_DONE
// byte handshake. DONE pulses once the trailer has been shifted out.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for START; inputs captured into shadows on accept
// SEND  | TX_START high for one cycle with the current byte on TX_DATA
// WAIT  | waiting for TX_DONE of the current byte
// FIN   | DONE high for one cycle, then back to IDLE
module mxv_result_tx #(
  parameter int          MAX_N   = 8,
  parameter int          RES_W   = 16,
  parameter logic [7:0]  HEADER  = 8'hFE,
  parameter logic [7:0]  TRAILER = 8'hEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   START,
  input  logic [3:0]             VEC_N,
  input  logic [MAX_N*RES_W-1:0] RES_DATA,
  input  logic                   TX_DONE,
  output logic                   TX_START,
  output logic [7:0]             TX_DATA,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int LEN_W = $clog2(MAX_N + 1);
  localparam int IDX_W = LEN_W + 1;
  localparam int EW    = $clog2(MAX_N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         chk_q, chk_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   len_q;
  logic [RES_W-1:0]   res_q [MAX_N];

  logic               accept;
  logic [LEN_W-1:0]   len_in;
  logic [IDX_W-1:0]   nxt_idx;
  logic [IDX_W-1:0]   didx;
  logic [IDX_W-1:0]   data_end;
  logic [IDX_W-1:0]   last_idx;
  logic [RES_W-1:0]   entry;
  logic [7:0]         nxt_byte;

  assign len_in   = (VEC_N > 4'(MAX_N)) ? LEN_W'(MAX_N) : LEN_W'(VEC_N);
  assign nxt_idx  = idx_q + IDX_W'(1);
  assign data_end = IDX_W'({len_q, 1'b1});
  assign last_idx = data_end + IDX_W'(2);

  // Byte mux: selects the byte that follows the current index from the shadows.
  always_comb begin
    didx  = nxt_idx - IDX_W'(2);
    entry = res_q[didx[EW:1]];
    if (nxt_idx == '0) begin
      nxt_byte = HEADER;
    end else if (nxt_idx == IDX_W'(1)) begin
      nxt_byte = 8'(len_q);
    end else if (nxt_idx <= data_end) begin
      nxt_byte = didx[0] ? entry[7:0] : entry[RES_W-1 -: 8];
    end else if (nxt_idx == data_end + IDX_W'(1)) begin
      nxt_byte = chk_q;
    end else begin
      nxt_byte = TRAILER;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          accept     = 1'b1;
          idx_d      = '0;
          chk_d      = 8'h00;
          tx_start_d = 1'b1;
          tx_data_d  = HEADER;
          busy_d     = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (TX_DONE) begin
          if (idx_q == last_idx) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            idx_d      = nxt_idx;
            tx_start_d = 1'b1;
            tx_data_d  = nxt_byte;
            // LEN and data bytes feed the checksum; CHK and TRAILER do not.
            if (nxt_idx <= data_end) chk_d = chk_q ^ nxt_byte;
            state_d    = S_SEND;
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      chk_q      <= 8'h00;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Shadow capture of length and results when a frame is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
      for (int i = 0; i < MAX_N; i++) res_q[i] <= '0;
    end else if (accept) begin
      len_q <= len_in;
      for (int i = 0; i < MAX_N; i++) res_q[i] <= RES_DATA[RES_W*i +: RES_W];
    end
  end

  assign TX_START = tx_start_q;
  assign TX_DATA  = tx_data_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_mxv_result_tx.sv
// Directed bench for mxv_result_tx with a byte scoreboard and a UART handshake stand-in.
module tb_mxv_result_tx;

  localparam int MAX_N = 8;
  localparam int RES_W = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   START = 1'b0;
  logic [3:0]             VEC_N = '0;
  logic [MAX_N*RES_W-1:0] RES_DATA = '0;
  logic                   TX_DONE = 1'b0;
  logic                   TX_START;
  logic [7:0]             TX_DATA;
  logic                   BUSY;
  logic                   DONE;

  int total = 0;
  int bad   = 0;
  int txs_cnt = 0;
  logic prev_txs = 1'b0;
  logic [7:0] exp_q[$];

  mxv_result_tx dut (
    .clk      (clk),
    .rst      (rst),
    .START    (START),
    .VEC_N    (VEC_N),
    .RES_DATA (RES_DATA),
    .TX_DONE  (TX_DONE),
    .TX_START (TX_START),
    .TX_DATA  (TX_DATA),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Pulse-shape monitor: TX_START never on consecutive cycles, never with DONE.
  always @(negedge clk) begin
    if (TX_START === 1'b1) txs_cnt++;
    total++;
    assert (!(TX_START === 1'b1 && (DONE === 1'b1 || prev_txs === 1'b1))) else begin
      bad++;
      $error("FAIL pulse_shape observed tx_start=%0b done=%0b prev=%0b expected exclusive", TX_START, DONE, prev_txs);
    end
    prev_txs = TX_START;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MAX_N*RES_W-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_model(input logic [3:0] n, input logic [MAX_N*RES_W-1:0] d);
    int len;
    logic [7:0] c;
    logic [15:0] e;
    len = (n > 8) ? 8 : int'(n);
    c = 8'(len);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      e = d[16*i +: 16];
      exp_q.push_back(e[15:8]);
      exp_q.push_back(e[7:0]);
      c = c ^ e[15:8] ^ e[7:0];
    end
    exp_q.push_back(c);
    exp_q.push_back(8'hEF);
  endtask

  task automatic run_frame(input logic [3:0] n, input logic [MAX_N*RES_W-1:0] d,
                           input int dly, input bit disturb, input int abort_after);
    logic [7:0] cur;
    int nb;
    int starts0;
    nb = exp_q.size();
    VEC_N = n;
    RES_DATA = d;
    START = 1'b1;
    tick();
    START = 1'b0;
    starts0 = txs_cnt;
    if (disturb) RES_DATA = ~d;
    for (int b = 0; b < nb; b++) begin
      cur = exp_q.pop_front();
      chk("tx_start_pulse", 32'(TX_START), 32'd1);
      chk("tx_data_byte", 32'(TX_DATA), 32'(cur));
      chk("busy_in_frame", 32'(BUSY), 32'd1);
      chk("no_done_in_frame", 32'(DONE), 32'd0);
      if (abort_after != 0 && b == abort_after) begin
        rst = 1'b0;
        #1;
        chk("rst_tx_start", 32'(TX_START), 32'd0);
        chk("rst_tx_data", 32'(TX_DATA), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        for (int j = 0; j < 3; j++) begin
          tick();
          chk("rst_no_done", 32'(DONE), 32'd0);
        end
        rst = 1'b1;
        tick();
        chk("post_rst_idle_busy", 32'(BUSY), 32'd0);
        chk("post_rst_idle_done", 32'(DONE), 32'd0);
        exp_q.delete();
        return;
      end
      for (int j = 0; j < dly; j++) begin
        if (disturb) begin
          TX_DONE = (j == 0);
          START = 1'b1;
          RES_DATA = rnd_vec();
          VEC_N = 4'($urandom_range(0, 15));
        end
        tick();
        TX_DONE = 1'b0;
        START = 1'b0;
        chk("tx_start_gap", 32'(TX_START), 32'd0);
        chk("tx_data_hold", 32'(TX_DATA), 32'(cur));
      end
      TX_DONE = 1'b1;
      tick();
      TX_DONE = 1'b0;
    end
    chk("done_pulse", 32'(DONE), 32'd1);
    chk("busy_at_done", 32'(BUSY), 32'd1);
    chk("tx_start_count", 32'(txs_cnt - starts0), 32'(nb));
    tick();
    chk("done_clear", 32'(DONE), 32'd0);
    chk("busy_clear", 32'(BUSY), 32'd0);
  endtask

  initial begin
    logic [MAX_N*RES_W-1:0] d;

    tick();
    tick();
    chk("reset_tx_start", 32'(TX_START), 32'd0);
    chk("reset_tx_data", 32'(TX_DATA), 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    rst = 1'b1;
    tick();

    TX_DONE = 1'b1;
    tick();
    TX_DONE = 1'b0;
    chk("idle_txdone_tx_start", 32'(TX_START), 32'd0);
    chk("idle_txdone_busy", 32'(BUSY), 32'd0);

    // Single result 0x1234: FE 01 12 34 27 EF.
    d = rnd_vec();
    d[15:0] = 16'h1234;
    exp_q = '{8'hFE, 8'h01, 8'h12, 8'h34, 8'h27, 8'hEF};
    run_frame(4'd1, d, 1, 1'b0, 0);

    // Empty vector: data contents irrelevant.
    exp_q = '{8'hFE, 8'h00, 8'h00, 8'hEF};
    run_frame(4'd0, rnd_vec(), 2, 1'b0, 0);

    // Full vector with clamp from 9, UART latency of 10 cycles.
    for (int i = 0; i < MAX_N; i++) d[16*i +: 16] = 16'(16'h0101 * (i + 1));
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'h08);
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    exp_q.push_back(8'h08);
    exp_q.push_back(8'hEF);
    run_frame(4'd9, d, 10, 1'b0, 0);

    // Robustness: extra START, TX_DONE on SEND cycles, RES_DATA churn.
    d = rnd_vec();
    push_model(4'd5, d);
    run_frame(4'd5, d, 3, 1'b1, 0);

    // Reset after the 3rd TX_DONE, then a clean frame.
    d = rnd_vec();
    push_model(4'd6, d);
    run_frame(4'd6, d, 2, 1'b0, 3);
    d = rnd_vec();
    push_model(4'd3, d);
    run_frame(4'd3, d, 1, 1'b0, 0);

    d = rnd_vec();
    push_model(4'd15, d);
    run_frame(4'd15, d, 1, 1'b0, 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
